dispensa_troco: RTL and testbench
=================================

DISPENSA_TROCO -- requirements
Module: dispensa_troco

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state changes on posedge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: on_off  input  1  machine enable; low aborts any operation.
REQ-004 SHALL have port: iniciar  input  1  start request, sampled in OCIOSO only.
REQ-005 SHALL have port: valor_troco  input  5  change amount owed, unsigned 0..31, captured with iniciar.
REQ-006 SHALL have port: moeda_ack  input  1  coin mechanism accepted the presented coin.
REQ-007 SHALL have port: moeda_sel  output  2  coin code: 01=2, 10=5, 11=10, 00=none; same code as the coin-input selector.
REQ-008 SHALL have port: moeda_valid  output  1  moeda_sel holds a coin to eject.
REQ-009 SHALL have port: ocupado  output  1  high in every state except OCIOSO.
REQ-010 SHALL have port: concluido  output  1  one-cycle pulse, change fully paid.
REQ-011 SHALL have port: troco_invalido  output  1  one-cycle pulse, amount not payable.
REQ-012 SHALL have port: restante  output  5  amount still owed.
REQ-013 SHALL have port: qtd_moedas  output  3  coins ejected in current/last operation.

Function
REQ-014 SHALL implement states OCIOSO, OFERTA, FIM; registered outputs only.
REQ-015 In OCIOSO with on_off=1 and iniciar=1: valor_troco in {1,3} SHALL pulse troco_invalido next cycle and stay OCIOSO.
REQ-016 In OCIOSO with iniciar=1 and valor_troco=0 SHALL go to FIM (concluido pulse next cycle, no coin).
REQ-017 In OCIOSO with iniciar=1 and other values SHALL load restante=valor_troco, clear qtd_moedas, enter OFERTA; moeda_valid=1 the next cycle.
REQ-018 Coin choice for remainder r SHALL be: 10 if r>=10 and r-10 not in {1,3}; else 5 if r>=5 and r-5 not in {1,3}; else 2.
REQ-019 In OFERTA moeda_valid SHALL stay 1 and moeda_sel stable until moeda_ack=1 is sampled.
REQ-020 On ack SHALL subtract coin value from restante and increment qtd_moedas in the same edge.
REQ-021 If new restante=0 SHALL enter FIM with moeda_valid=0, moeda_sel=00; else stay OFERTA presenting the next coin the following cycle (no idle cycle).
REQ-022 FIM SHALL last exactly one cycle with concluido=1, then return to OCIOSO.
REQ-023 moeda_ack while moeda_valid=0 SHALL be ignored.
REQ-024 iniciar while ocupado=1 SHALL be ignored; valor_troco changes after capture SHALL have no effect.
REQ-025 restante SHALL never underflow; qtd_moedas max 6 (31=10+10+5+2+2+2), no wrap.
REQ-026 on_off=0 in any state SHALL return to OCIOSO next edge, restante and moeda_valid cleared, no concluido pulse; qtd_moedas held.
REQ-027 concluido and troco_invalido SHALL never be high in the same cycle.

Reset
REQ-028 reset=1 SHALL override on_off, iniciar and moeda_ack at the same edge.
REQ-029 After reset: state OCIOSO, moeda_sel=00, moeda_valid=0, ocupado=0, concluido=0, troco_invalido=0, restante=0, qtd_moedas=0.
REQ-030 Reset asserted mid-OFERTA SHALL abort the operation without a concluido pulse.

Verification
REQ-031 valor_troco=17, ack every valid cycle -> coins 11,10,01 (10,5,2) on consecutive cycles, concluido pulse, qtd_moedas=3, restante=0.
REQ-032 valor_troco=13 -> coins 5,2,2,2,2 (never 10), qtd_moedas=5; valor_troco=6 -> 2,2,2.
REQ-033 valor_troco=3 -> troco_invalido one cycle, moeda_valid stays 0, ocupado stays 0; valor_troco=0 -> concluido next cycle, qtd_moedas=0.
REQ-034 valor_troco=31, ack held low 4 cycles on first coin -> moeda_sel=11 stable all 4 cycles; then 10,10,5,2,2,2, qtd_moedas=6.
REQ-035 valor_troco=25, reset high after first ack -> next cycle all outputs at reset values, no concluido; same with on_off=0 -> OCIOSO, qtd_moedas=1 held.
REQ-036 iniciar pulsed with valor_troco=10 while dispensing 7 -> ignored; sequence 5,2 unaffected.

Source files
------------

// File: rtl/dispensa_troco_if.sv
// Change-dispenser handshake: control inputs, coin presentation and status.
interface dispensa_troco_if;
  logic       on_off;
  logic       iniciar;
  logic [4:0] valor_troco;
  logic       moeda_ack;
  logic [1:0] moeda_sel;
  logic       moeda_valid;
  logic       ocupado;
  logic       concluido;
  logic       troco_invalido;
  logic [4:0] restante;
  logic [2:0] qtd_moedas;

  // Dispenser side
  modport slave (
    input  on_off, iniciar, valor_troco, moeda_ack,
    output moeda_sel, moeda_valid, ocupado, concluido, troco_invalido,
           restante, qtd_moedas
  );

  // Controller / coin-mechanism side
  modport master (
    output on_off, iniciar, valor_troco, moeda_ack,
    input  moeda_sel, moeda_valid, ocupado, concluido, troco_invalido,
           restante, qtd_moedas
  );
endinterface

// File: rtl/dispensa_troco.sv
// Change dispenser: pays valor_troco with 10/5/2 coins, one coin per ack.
module dispensa_troco (
  input logic               clock,
  input logic               reset,
  dispensa_troco_if.slave   bus
);

  localparam int unsigned VW = 5;
  localparam int unsigned QW = 3;
  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] SEL_NONE = 2'b00;
  localparam logic [SW-1:0] SEL_2    = 2'b01;
  localparam logic [SW-1:0] SEL_5    = 2'b10;
  localparam logic [SW-1:0] SEL_10   = 2'b11;

  typedef enum logic [1:0] {OCIOSO, OFERTA, FIM} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          valid_q, valid_d;
  logic          ocupado_q;
  logic          concl_q, concl_d;
  logic          inval_q, inval_d;
  logic [VW-1:0] rest_q, rest_d;
  logic [QW-1:0] qtd_q, qtd_d;
  logic [VW-1:0] valor_atual;

  // Largest coin that never leaves an unpayable remainder (1 or 3)
  function automatic logic [SW-1:0] escolhe_moeda(input logic [VW-1:0] r);
    if (r >= VW'(10) && r != VW'(11) && r != VW'(13)) return SEL_10;
    else if (r >= VW'(5) && r != VW'(6) && r != VW'(8)) return SEL_5;
    else return SEL_2;
  endfunction

  // Face value of a coin code
  function automatic logic [VW-1:0] valor_moeda(input logic [SW-1:0] s);
    case (s)
      SEL_2:   return VW'(2);
      SEL_5:   return VW'(5);
      SEL_10:  return VW'(10);
      default: return VW'(0);
    endcase
  endfunction

  assign valor_atual = valor_moeda(sel_q);

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= OCIOSO;
      sel_q     <= SEL_NONE;
      valid_q   <= 1'b0;
      ocupado_q <= 1'b0;
      concl_q   <= 1'b0;
      inval_q   <= 1'b0;
      rest_q    <= '0;
      qtd_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      ocupado_q <= (state_d != OCIOSO);
      concl_q   <= concl_d;
      inval_q   <= inval_d;
      rest_q    <= rest_d;
      qtd_q     <= qtd_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    concl_d = 1'b0;
    inval_d = 1'b0;
    rest_d  = rest_q;
    qtd_d   = qtd_q;

    if (!bus.on_off) begin
      // Abort: keep coin count of the interrupted operation
      state_d = OCIOSO;
      sel_d   = SEL_NONE;
      valid_d = 1'b0;
      rest_d  = '0;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (bus.iniciar) begin
            if (bus.valor_troco == VW'(1) || bus.valor_troco == VW'(3)) begin
              inval_d = 1'b1;
            end else if (bus.valor_troco == '0) begin
              state_d = FIM;
              concl_d = 1'b1;
              rest_d  = '0;
              qtd_d   = '0;
            end else begin
              state_d = OFERTA;
              rest_d  = bus.valor_troco;
              qtd_d   = '0;
              sel_d   = escolhe_moeda(bus.valor_troco);
              valid_d = 1'b1;
            end
          end
        end
        OFERTA: begin
          if (bus.moeda_ack && valid_q) begin
            rest_d = (rest_q >= valor_atual) ? rest_q - valor_atual : '0;
            if (qtd_q != '1) qtd_d = qtd_q + QW'(1);
            if (rest_d == '0) begin
              state_d = FIM;
              concl_d = 1'b1;
              sel_d   = SEL_NONE;
              valid_d = 1'b0;
            end else begin
              sel_d   = escolhe_moeda(rest_d);
            end
          end
        end
        FIM: begin
          state_d = OCIOSO;
        end
        default: begin
          state_d = OCIOSO;
          sel_d   = SEL_NONE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.moeda_sel      = sel_q;
  assign bus.moeda_valid    = valid_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.concluido      = concl_q;
  assign bus.troco_invalido = inval_q;
  assign bus.restante       = rest_q;
  assign bus.qtd_moedas     = qtd_q;

endmodule

// File: tb/tb_dispensa_troco.sv
// Directed bench for dispensa_troco with hand-computed coin sequences.
module tb_dispensa_troco;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [1:0] exp_coins [8];

  dispensa_troco_if bus ();

  dispensa_troco dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_idle(input string tag, input logic [2:0] qtd);
    check({tag, ".sel"},     8'(bus.moeda_sel), 8'd0);
    check({tag, ".valid"},   8'(bus.moeda_valid), 8'd0);
    check({tag, ".ocupado"}, 8'(bus.ocupado), 8'd0);
    check({tag, ".concl"},   8'(bus.concluido), 8'd0);
    check({tag, ".inval"},   8'(bus.troco_invalido), 8'd0);
    check({tag, ".rest"},    8'(bus.restante), 8'd0);
    check({tag, ".qtd"},     8'(bus.qtd_moedas), 8'(qtd));
  endtask

  // Issue a start request for one cycle
  task automatic start(input logic [4:0] v, input logic ack);
    bus.iniciar     = 1'b1;
    bus.valor_troco = v;
    bus.moeda_ack   = ack;
    tick();
    bus.iniciar     = 1'b0;
    bus.valor_troco = 5'd0;
  endtask

  // With ack held high, expect exp_coins[0..n-1] then the completion cycle
  task automatic follow(input string tag, input int n);
    bus.moeda_ack = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, ".sel"},   8'(bus.moeda_sel), 8'(exp_coins[i]));
      check({tag, ".valid"}, 8'(bus.moeda_valid), 8'd1);
      tick();
    end
    check({tag, ".concl"},  8'(bus.concluido), 8'd1);
    check({tag, ".valid0"}, 8'(bus.moeda_valid), 8'd0);
    check({tag, ".sel0"},   8'(bus.moeda_sel), 8'd0);
    check({tag, ".rest"},   8'(bus.restante), 8'd0);
    check({tag, ".qtd"},    8'(bus.qtd_moedas), 8'(n));
    check({tag, ".inval"},  8'(bus.troco_invalido), 8'd0);
    tick();
    check({tag, ".concl_end"}, 8'(bus.concluido), 8'd0);
    check({tag, ".ocup_end"},  8'(bus.ocupado), 8'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset           = 1'b1;
    bus.on_off      = 1'b1;
    bus.iniciar     = 1'b1;
    bus.valor_troco = 5'd17;
    bus.moeda_ack   = 1'b1;
    tick();
    tick();
    bus.iniciar   = 1'b0;
    bus.moeda_ack = 1'b0;
    check_idle("reset", 3'd0);
    reset = 1'b0;
    bus.moeda_ack = 1'b1;
    tick();
    check_idle("idle_ack", 3'd0);

    // 17 -> 10,5,2
    exp_coins = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    start(5'd17, 1'b1);
    check("v17.rest0", 8'(bus.restante), 8'd17);
    follow("v17", 3);

    // 13 -> 5,2,2,2,2
    exp_coins = '{2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    start(5'd13, 1'b1);
    follow("v13", 5);

    // 6 -> 2,2,2
    exp_coins = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    start(5'd6, 1'b1);
    follow("v6", 3);

    // Unpayable amounts
    start(5'd3, 1'b1);
    check("v3.inval", 8'(bus.troco_invalido), 8'd1);
    check("v3.valid", 8'(bus.moeda_valid), 8'd0);
    check("v3.ocup",  8'(bus.ocupado), 8'd0);
    check("v3.concl", 8'(bus.concluido), 8'd0);
    tick();
    check("v3.inval_end", 8'(bus.troco_invalido), 8'd0);
    start(5'd1, 1'b1);
    check("v1.inval", 8'(bus.troco_invalido), 8'd1);
    tick();

    // Zero amount: immediate completion, count cleared
    start(5'd0, 1'b1);
    check("v0.concl", 8'(bus.concluido), 8'd1);
    check("v0.qtd",   8'(bus.qtd_moedas), 8'd0);
    check("v0.valid", 8'(bus.moeda_valid), 8'd0);
    check("v0.ocup",  8'(bus.ocupado), 8'd1);
    tick();
    check("v0.concl_end", 8'(bus.concluido), 8'd0);

    // 31 with first ack delayed 4 cycles
    start(5'd31, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("v31.hold_sel",   8'(bus.moeda_sel), 8'd3);
      check("v31.hold_valid", 8'(bus.moeda_valid), 8'd1);
      check("v31.hold_rest",  8'(bus.restante), 8'd31);
      tick();
    end
    exp_coins = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    follow("v31", 6);

    // 25 aborted by reset after first ack
    start(5'd25, 1'b1);
    tick();
    check("v25r.rest", 8'(bus.restante), 8'd15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("v25r", 3'd0);
    tick();
    check("v25r.concl", 8'(bus.concluido), 8'd0);

    // 25 aborted by on_off after first ack: count held
    start(5'd25, 1'b1);
    tick();
    bus.on_off = 1'b0;
    tick();
    bus.on_off = 1'b1;
    check_idle("v25o", 3'd1);
    tick();
    check("v25o.concl", 8'(bus.concluido), 8'd0);

    // 7 with a stray start request mid-operation
    start(5'd7, 1'b1);
    check("v7.sel0", 8'(bus.moeda_sel), 8'd2);
    bus.iniciar     = 1'b1;
    bus.valor_troco = 5'd10;
    tick();
    bus.iniciar     = 1'b0;
    check("v7.rest1", 8'(bus.restante), 8'd2);
    exp_coins = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    check("v7.sel1", 8'(bus.moeda_sel), 8'd1);
    tick();
    check("v7.concl", 8'(bus.concluido), 8'd1);
    check("v7.qtd",   8'(bus.qtd_moedas), 8'd2);
    tick();
    check("v7.ocup_end", 8'(bus.ocupado), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
